// File: rtl/uart_tx_arbiter.sv
// -----------------------------------------------------------------------------
// uart_tx_arbiter
//
// Purpose:
//   Shares one UART TX byte stream between three message requesters. Each
//   request produces one frame: a header byte that identifies the requester,
//   followed by its 16-bit payload, high byte first. Requester 0 (control)
//   always wins. Requesters 1 (keeper) and 2 (shot) alternate round-robin
//   when both are waiting.
//
// Optional feature:
//   `define UART_TX_CHECKSUM_EN adds a fourth byte to every frame:
//   header ^ payload[15:8] ^ payload[7:0]. It is sent after the low byte.
//
// Handshake:
//   A byte is transferred in any cycle where tx_wr=1 and tx_ready=1. tx_wr is
//   combinational: it is high in every SEND_* state while tx_ready is high.
//   A SEND_* state moves to the next state only on a transfer, so the FSM
//   waits while tx_ready is low.
//   req is a level that the requester holds until it sees its ack bit.
//   ack pulses for one cycle, and that cycle is the DONE state.
//
// Ports:
//   clk                 in   system clock, rising edge
//   rst                 in   asynchronous reset, active low
//   req[2:0]            in   per-requester message request (level)
//   payload0..2[15:0]   in   message payloads of requesters 0..2
//   ack[2:0]            out  one-cycle completion pulse per requester
//   tx_ready            in   UART TX FIFO not full
//   tx_wr               out  byte write strobe to UART TX
//   tx_data[7:0]        out  byte to UART TX
//   busy                out  high whenever the FSM is not in IDLE
//   dbg_state[2:0]      out  current FSM state encoding (debug visibility)
// -----------------------------------------------------------------------------
module uart_tx_arbiter #(
   parameter logic [7:0] HDR_CTRL   = 8'hC0,
   parameter logic [7:0] HDR_KEEPER = 8'hA0,
   parameter logic [7:0] HDR_SHOT   = 8'hB0
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [2:0]  req,
   input  logic [15:0] payload0,
   input  logic [15:0] payload1,
   input  logic [15:0] payload2,
   output logic [2:0]  ack,
   input  logic        tx_ready,
   output logic        tx_wr,
   output logic [7:0]  tx_data,
   output logic        busy,
   output logic [2:0]  dbg_state
);

   typedef enum logic [2:0] {
      IDLE     = 3'd0,
      SEND_HDR = 3'd1,
      SEND_HI  = 3'd2,
      SEND_LO  = 3'd3,
`ifdef UART_TX_CHECKSUM_EN
      SEND_CK  = 3'd4,
`endif
      DONE     = 3'd5
   } state_t;

   state_t      state_q;
   logic [15:0] payload_q;
   logic [1:0]  idx_q;
   logic        rr_q;      // 0: requester 1 is favoured, 1: requester 2 is favoured
   logic [2:0]  ack_q;

   logic        grant_vld_d;
   logic [1:0]  grant_idx_d;
   logic [15:0] grant_payload_d;
   logic [7:0]  hdr_byte;
   logic        send_state;

   // Grant selection, used only in IDLE.
   always_comb begin
      grant_vld_d = |req;
      grant_idx_d = 2'd0;
      if (req[0]) begin
         grant_idx_d = 2'd0;
      end else if (req[1] && req[2]) begin
         grant_idx_d = rr_q ? 2'd2 : 2'd1;
      end else if (req[1]) begin
         grant_idx_d = 2'd1;
      end else if (req[2]) begin
         grant_idx_d = 2'd2;
      end

      case (grant_idx_d)
         2'd1:    grant_payload_d = payload1;
         2'd2:    grant_payload_d = payload2;
         default: grant_payload_d = payload0;
      endcase
   end

   always_comb begin
      case (idx_q)
         2'd1:    hdr_byte = HDR_KEEPER;
         2'd2:    hdr_byte = HDR_SHOT;
         default: hdr_byte = HDR_CTRL;
      endcase
   end

   always_comb begin
      send_state = 1'b0;
      tx_data    = 8'h00;
      case (state_q)
         SEND_HDR: begin
            send_state = 1'b1;
            tx_data    = hdr_byte;
         end
         SEND_HI: begin
            send_state = 1'b1;
            tx_data    = payload_q[15:8];
         end
         SEND_LO: begin
            send_state = 1'b1;
            tx_data    = payload_q[7:0];
         end
`ifdef UART_TX_CHECKSUM_EN
         SEND_CK: begin
            send_state = 1'b1;
            tx_data    = hdr_byte ^ payload_q[15:8] ^ payload_q[7:0];
         end
`endif
         default: begin
            send_state = 1'b0;
            tx_data    = 8'h00;
         end
      endcase
   end

   assign tx_wr     = send_state & tx_ready;
   assign ack       = ack_q;
   assign busy      = (state_q != IDLE);
   assign dbg_state = state_q;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q   <= IDLE;
         payload_q <= 16'h0000;
         idx_q     <= 2'd0;
         rr_q      <= 1'b0;
         ack_q     <= 3'b000;
      end else begin
         ack_q <= 3'b000;
         case (state_q)
            IDLE: begin
               if (grant_vld_d) begin
                  payload_q <= grant_payload_d;
                  idx_q     <= grant_idx_d;
                  // The round-robin pointer only moves when 1 or 2 wins.
                  // A grant to 0 leaves the pointer unchanged.
                  if (grant_idx_d == 2'd1) rr_q <= 1'b1;
                  if (grant_idx_d == 2'd2) rr_q <= 1'b0;
                  state_q <= SEND_HDR;
               end
            end
            SEND_HDR: if (tx_ready) state_q <= SEND_HI;
            SEND_HI:  if (tx_ready) state_q <= SEND_LO;
            SEND_LO: begin
               if (tx_ready) begin
`ifdef UART_TX_CHECKSUM_EN
                  state_q <= SEND_CK;
`else
                  state_q <= DONE;
                  ack_q   <= 3'b001 << idx_q;
`endif
               end
            end
`ifdef UART_TX_CHECKSUM_EN
            SEND_CK: begin
               if (tx_ready) begin
                  state_q <= DONE;
                  ack_q   <= 3'b001 << idx_q;
               end
            end
`endif
            DONE:     state_q <= IDLE;
            default:  state_q <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// -----------------------------------------------------------------------------
// tb_uart_tx_arbiter
//
// Directed testbench for uart_tx_arbiter.
// - Inputs change 1 time unit after the rising clock edge.
// - A monitor records every written byte, with its cycle number, on the
//   falling clock edge.
// - Expected bytes come from a small frame model and are kept in exp_q.
// Define UART_TX_CHECKSUM_EN for the bench and the RTL together to build the
// 4-byte-frame variant.
// -----------------------------------------------------------------------------
module tb_uart_tx_arbiter;

`ifdef UART_TX_CHECKSUM_EN
   localparam int NB = 4;
`else
   localparam int NB = 3;
`endif

   logic        clk = 1'b0;
   logic        rst;
   logic [2:0]  req;
   logic [15:0] payload0, payload1, payload2;
   logic [2:0]  ack;
   logic        tx_ready;
   logic        tx_wr;
   logic [7:0]  tx_data;
   logic        busy;
   logic [2:0]  dbg_state;

   int n_tests = 0;
   int n_fail  = 0;
   int cyc     = 0;

   logic [7:0] wr_q[$];
   int         wr_cyc[$];
   logic [7:0] exp_q[$];

   always #5 clk = ~clk;

   uart_tx_arbiter dut (
      .clk       (clk),
      .rst       (rst),
      .req       (req),
      .payload0  (payload0),
      .payload1  (payload1),
      .payload2  (payload2),
      .ack       (ack),
      .tx_ready  (tx_ready),
      .tx_wr     (tx_wr),
      .tx_data   (tx_data),
      .busy      (busy),
      .dbg_state (dbg_state)
   );

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (tx_wr === 1'b1) begin
         wr_q.push_back(tx_data);
         wr_cyc.push_back(cyc);
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Waits for a non-zero ack, for at most 40 cycles.
   // Returns the ack value (0 if the wait times out) and the number of cycles waited.
   task automatic wait_ack(output logic [2:0] a, output int n);
      a = 3'b000;
      n = 0;
      for (int i = 0; i < 40; i++) begin
         tick();
         n = i + 1;
         if (ack !== 3'b000) begin
            a = ack;
            break;
         end
      end
   endtask

   // Frame model: header, payload high byte, payload low byte, and the optional checksum.
   task automatic push_frame(input logic [7:0] hdr, input logic [15:0] pl);
      exp_q.push_back(hdr);
      exp_q.push_back(pl[15:8]);
      exp_q.push_back(pl[7:0]);
`ifdef UART_TX_CHECKSUM_EN
      exp_q.push_back(hdr ^ pl[15:8] ^ pl[7:0]);
`endif
   endtask

   task automatic check_stream(input string tag);
      int n;
      check({tag, "_len"}, wr_q.size(), exp_q.size());
      n = (wr_q.size() < exp_q.size()) ? wr_q.size() : exp_q.size();
      for (int i = 0; i < n; i++) begin
         check($sformatf("%s_byte%0d", tag, i), {24'h0, wr_q[i]}, {24'h0, exp_q[i]});
      end
      wr_q.delete();
      wr_cyc.delete();
      exp_q.delete();
   endtask

   task automatic apply_reset();
      rst = 1'b0;
      tick();
      tick();
      rst = 1'b1;
      wr_q.delete();
      wr_cyc.delete();
      exp_q.delete();
   endtask

   initial begin
      logic [2:0] a;
      int         n;
      int         bad;

      rst      = 1'b0;
      req      = 3'b000;
      payload0 = 16'h0000;
      payload1 = 16'h0000;
      payload2 = 16'h0000;
      tx_ready = 1'b1;

      // Reset state. tx_wr must stay low in IDLE even though tx_ready is high.
      #2;
      check("rst_ack",     ack,       3'b000);
      check("rst_busy",    busy,      1'b0);
      check("rst_tx_wr",   tx_wr,     1'b0);
      check("rst_tx_data", tx_data,   8'h00);
      check("rst_state",   dbg_state, 3'd0);
      apply_reset();

      // Single keeper frame: bytes A0 12 34, then the ack, then idle.
      req      = 3'b010;
      payload1 = 16'h1234;
      wait_ack(a, n);
      check("t1_ack",      a,       3'b010);
      check("t1_latency",  n,       NB + 1);
      check("t1_done_wr",  tx_wr,   1'b0);
      check("t1_done_dat", tx_data, 8'h00);
      check("t1_done_bsy", busy,    1'b1);
      req = 3'b000;
      tick();
      check("t1_idle_busy", busy, 1'b0);
      check("t1_idle_ack",  ack,  3'b000);
      if (wr_cyc.size() == NB) check("t1_b2b", wr_cyc[NB-1] - wr_cyc[0], NB - 1);
      else                     check("t1_b2b_cnt", wr_cyc.size(), NB);
      push_frame(8'hA0, 16'h1234);
      check_stream("t1");

      // All three requesters at once after reset.
      // The expected order is 0, then 1, then 2.
      // Each requester drops its req when it sees its ack.
      apply_reset();
      payload0 = 16'h0102;
      payload1 = 16'h0304;
      payload2 = 16'h0506;
      req      = 3'b111;
      wait_ack(a, n);
      check("t2_ack0", a, 3'b001);
      req = 3'b110;
      wait_ack(a, n);
      check("t2_ack1", a, 3'b010);
      req = 3'b100;
      wait_ack(a, n);
      check("t2_ack2", a, 3'b100);
      req = 3'b000;
      tick();
      push_frame(8'hC0, 16'h0102);
      push_frame(8'hA0, 16'h0304);
      push_frame(8'hB0, 16'h0506);
      check_stream("t2");

      // req[1] and req[2] held high: frames alternate A0, B0, A0, B0.
      // Frames are NB+2 cycles apart.
      payload1 = 16'h1234;
      payload2 = 16'h5678;
      req      = 3'b110;
      for (int i = 0; i < 80; i++) begin
         tick();
         if (wr_q.size() >= 4 * NB) break;
      end
      req = 3'b000;
      tick();
      tick();
      check("t3_busy_end", busy, 1'b0);
      if (wr_cyc.size() >= 4 * NB) begin
         check("t3_period01", wr_cyc[NB]   - wr_cyc[0],    NB + 2);
         check("t3_period23", wr_cyc[3*NB] - wr_cyc[2*NB], NB + 2);
      end else begin
         check("t3_write_cnt", wr_cyc.size(), 4 * NB);
      end
      push_frame(8'hA0, 16'h1234);
      push_frame(8'hB0, 16'h5678);
      push_frame(8'hA0, 16'h1234);
      push_frame(8'hB0, 16'h5678);
      check_stream("t3");

      // tx_ready low for 10 cycles after the header.
      // The header is written once, nothing is written during the stall, and the rest follows.
      payload0 = 16'hBEEF;
      req      = 3'b001;
      tick();
      check("t4_hdr_wr",   tx_wr,   1'b1);
      check("t4_hdr_data", tx_data, 8'hC0);
      tick();
      tx_ready = 1'b0;
      #1;
      check("t4_stall_wr", tx_wr, 1'b0);
      bad = 0;
      for (int i = 0; i < 10; i++) begin
         tick();
         if (tx_wr !== 1'b0 || ack !== 3'b000) bad++;
      end
      check("t4_stall_quiet", bad,         0);
      check("t4_stall_busy",  busy,        1'b1);
      check("t4_stall_cnt",   wr_q.size(), 1);
      tx_ready = 1'b1;
      wait_ack(a, n);
      check("t4_ack", a, 3'b001);
      req = 3'b000;
      tick();
      push_frame(8'hC0, 16'hBEEF);
      check_stream("t4");

      // Reset asserted during SEND_HI.
      // The frame is dropped with no ack, and the next frame starts with its header.
      payload2 = 16'h9A9B;
      req      = 3'b100;
      tick();
      tick();
      check("t5_in_hi", dbg_state, 3'd2);
      rst = 1'b0;
      #1;
      check("t5_rst_wr",   tx_wr,   1'b0);
      check("t5_rst_busy", busy,    1'b0);
      check("t5_rst_ack",  ack,     3'b000);
      check("t5_rst_data", tx_data, 8'h00);
      bad = 0;
      for (int i = 0; i < 3; i++) begin
         tick();
         if (ack !== 3'b000 || tx_wr !== 1'b0) bad++;
      end
      check("t5_rst_quiet", bad, 0);
      rst = 1'b1;
      wait_ack(a, n);
      check("t5_ack", a, 3'b100);
      req = 3'b000;
      tick();
      exp_q.push_back(8'hB0);
      push_frame(8'hB0, 16'h9A9B);
      check_stream("t5");

      // Control frame with payload 0F0F. The checksum byte, when built in, is C0.
      // The payload changes in the middle of the frame, which must not affect the frame.
      // req stays high after the ack, so a second frame is sent.
      payload0 = 16'h0F0F;
      req      = 3'b001;
      tick();
      payload0 = 16'h5AA5;
      wait_ack(a, n);
      check("t6_ack_a", a, 3'b001);
      wait_ack(a, n);
      check("t6_ack_b", a, 3'b001);
      check("t6_gap",   n, NB + 2);
      req = 3'b000;
      tick();
      push_frame(8'hC0, 16'h0F0F);
      push_frame(8'hC0, 16'h5AA5);
      check_stream("t6");

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/uart_tx_arbiter.md
UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 SHALL have parameter HDR_CTRL, default 8'hC0, header byte for requester 0 (game-state/control messages).
REQ-002 SHALL have parameter HDR_KEEPER, default 8'hA0, header byte for requester 1 (keeper position).
REQ-003 SHALL have parameter HDR_SHOT, default 8'hB0, header byte for requester 2 (shot/ball position).
REQ-004 SHALL have port clk  input  1  single system clock; all logic on rising edge.
REQ-005 SHALL have port rst  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port req  input  3  per-requester message request, level, held until ack.
REQ-007 SHALL have ports payload0, payload1, payload2  input  16 each  message payloads of requesters 0..2.
REQ-008 SHALL have port ack  output  3  one-cycle completion pulse per requester.
REQ-009 SHALL have port tx_ready  input  1  UART TX FIFO not full; byte accepted when tx_wr=1 and tx_ready=1.
REQ-010 SHALL have port tx_wr  output  1  byte write strobe to UART TX.
REQ-011 SHALL have port tx_data  output  8  byte to UART TX.
REQ-012 SHALL have port busy  output  1  high whenever state is not IDLE.

Function
REQ-013 SHALL implement states IDLE, SEND_HDR, SEND_HI, SEND_LO, (SEND_CK, see Configuration), DONE.
REQ-014 In IDLE with any req bit set, SHALL grant exactly one requester and enter SEND_HDR next cycle.
REQ-015 Priority SHALL be: requester 0 absolute; between 1 and 2 round-robin, favouring the one not granted most recently; after reset, 1 favoured.
REQ-016 SHALL latch the granted requester's payload and index in the grant cycle; later payload or req changes SHALL NOT alter the message in flight.
REQ-017 Frame byte order SHALL be: header (per parameter), payload[15:8], payload[7:0].
REQ-018 tx_wr SHALL be combinational: 1 iff state is a SEND_* state and tx_ready=1; tx_data SHALL hold the current state's byte (8'h00 in IDLE/DONE).
REQ-019 A SEND_* state SHALL advance only in a cycle where tx_wr=1; with tx_ready=0 it SHALL hold indefinitely, bytes written back-to-back when tx_ready stays high.
REQ-020 After the last byte write, state SHALL be DONE for exactly one cycle with ack[granted]=1 (registered), then IDLE.
REQ-021 A req dropped before ack SHALL NOT abort the frame; the frame completes and ack still pulses.
REQ-022 A req still high in the first IDLE cycle after DONE SHALL be treated as a new request.
REQ-023 Minimum frame period SHALL be 5 cycles (IDLE, 3 bytes, DONE); 6 with checksum.
REQ-024 Simultaneous req=3'b111 SHALL serve order 0, then 1/2 per round-robin, as each is re-presented.

Reset
REQ-025 While rst=0: state=IDLE, ack=3'b000, busy=0, tx_wr=0, tx_data=8'h00, round-robin pointer favours 1, latched payload/index cleared.
REQ-026 Reset asserted mid-frame SHALL abandon the frame without ack; no further bytes written after rst falls.

Configuration
REQ-027 Macro UART_TX_CHECKSUM_EN defined: SHALL insert SEND_CK after SEND_LO sending header XOR payload[15:8] XOR payload[7:0] (4-byte frame).
REQ-028 Macro undefined: SEND_CK SHALL not exist; frames are 3 bytes.

Verification
REQ-029 req=3'b010, payload1=16'h1234, tx_ready=1 -> tx_data A0,12,34 on 3 consecutive tx_wr cycles, ack=3'b010 one cycle later, busy low after.
REQ-030 req=3'b111 simultaneously, requesters dropping req on their ack -> frames sent in order C0, A0, B0 headers.
REQ-031 req[1] and req[2] held high continuously -> headers alternate A0,B0,A0,B0; each frame 5 cycles apart.
REQ-032 tx_ready low for 10 cycles after header -> header written once, no tx_wr during stall, remaining bytes follow on release, no duplication.
REQ-033 rst=0 during SEND_HI -> no ack, tx_wr=0 immediately, next frame after reset starts with its header.
REQ-034 With UART_TX_CHECKSUM_EN, payload0=16'h0F0F -> bytes C0,0F,0F,C0 then ack=3'b001.
